// File: rtl/fp_add_pkg.sv
// -----------------------------------------------------------------------------
// fp_add_pkg
// Shared widths, codes and the normalizer beat type for the floating adder.
//   MANT_W     : significand width including the hidden bit
//   EXP_W      : exponent width (passed through the normalizer)
//   SHIFT_W    : width of the shift code handed to exponent adjust
//   CARRY_CODE : shift code meaning "carry out: shift right 1, increment exp"
// -----------------------------------------------------------------------------
package fp_add_pkg;

   localparam int MANT_W     = 24;
   localparam int EXP_W      = 8;
   localparam int SHIFT_W    = 5;
   localparam int CARRY_CODE = 28;

   typedef struct packed {
      logic [MANT_W-1:0]  mant;
      logic [SHIFT_W-1:0] shift;
      logic [EXP_W-1:0]   exp;
      logic               sign;
      logic               zero;
      logic               sticky;
   } norm_beat_t;

endpackage

// File: rtl/fp_lzc.sv
// -----------------------------------------------------------------------------
// fp_lzc
// Combinational leading-zero counter with an all-zero flag.
// Ports:
//   din      in  W      value to scan, MSB first
//   cnt      out CNT_W  number of leading zeros (0 when din is all zero)
//   all_zero out 1      din == 0
// -----------------------------------------------------------------------------
module fp_lzc
   import fp_add_pkg::*;
#(
   parameter int W     = MANT_W,
   parameter int CNT_W = SHIFT_W
) (
   input  logic [W-1:0]     din,
   output logic [CNT_W-1:0] cnt,
   output logic             all_zero
);

   // Scanning upward lets the highest set bit overwrite any lower one.
   always_comb begin
      cnt      = '0;
      all_zero = (din == '0);
      for (int i = 0; i < W; i++) begin
         if (din[i]) begin
            cnt = CNT_W'(W - 1 - i);
         end
      end
   end

endmodule

// File: rtl/fp_add_normalizer.sv
// -----------------------------------------------------------------------------
// fp_add_normalizer
// Two-stage normalizer between the significand adder and exponent adjust.
// Stage 1 classifies the raw sum (carry / leading zeros / zero), stage 2
// shifts the significand and forms the shift code. Exponent and sign ride
// along unchanged.
// Optional feature macro: FP_NORM_STICKY_EN (drives out_sticky with the bit
// dropped by the carry right-shift; otherwise out_sticky is constant 0).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready      input handshake
//   in_sum  [MANT_W:0]     raw sum, MSB is the carry
//   in_exp, in_sign        bigger exponent and result sign
//   out_valid/out_ready    output handshake
//   out_mant [MANT_W-1:0]  normalized significand
//   out_shift[SHIFT_W-1:0] leading-zero count, or CARRY_CODE on carry out
//   out_exp, out_sign      pass-through
//   out_zero               sum was exactly zero
//   out_sticky             bit lost on the carry right-shift
// -----------------------------------------------------------------------------
module fp_add_normalizer
   import fp_add_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MANT_W:0]    in_sum,
   input  logic [EXP_W-1:0]   in_exp,
   input  logic               in_sign,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [MANT_W-1:0]  out_mant,
   output logic [SHIFT_W-1:0] out_shift,
   output logic [EXP_W-1:0]   out_exp,
   output logic               out_sign,
   output logic               out_zero,
   output logic               out_sticky
);

   // A leading-zero count must never alias the carry code, and the code
   // must fit in the shift field.
   generate
      if (CARRY_CODE < MANT_W) begin : g_bad_carry_code
         $error("fp_add_normalizer: CARRY_CODE must be >= MANT_W");
      end
      if (CARRY_CODE >= (1 << SHIFT_W)) begin : g_bad_shift_w
         $error("fp_add_normalizer: CARRY_CODE does not fit in SHIFT_W");
      end
   endgenerate

   logic vld_p1, vld_p2;
   logic adv1, adv2;

   assign adv2     = !vld_p2 || out_ready;
   assign adv1     = !vld_p1 || adv2;
   assign in_ready = adv1;

   // ---- stage 1: classify ----
   logic [SHIFT_W-1:0] lzc_in;
   logic               low_zero;

   fp_lzc #(.W(MANT_W), .CNT_W(SHIFT_W)) u_lzc (
      .din      (in_sum[MANT_W-1:0]),
      .cnt      (lzc_in),
      .all_zero (low_zero)
   );

   logic [MANT_W:0]    sum_p1;
   logic [EXP_W-1:0]   exp_p1;
   logic               sign_p1;
   logic               carry_p1;
   logic [SHIFT_W-1:0] lzc_p1;
   logic               zero_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1 <= 1'b0;
      end else if (adv1) begin
         vld_p1 <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (adv1 && in_valid) begin
         sum_p1   <= in_sum;
         exp_p1   <= in_exp;
         sign_p1  <= in_sign;
         carry_p1 <= in_sum[MANT_W];
         lzc_p1   <= lzc_in;
         zero_p1  <= !in_sum[MANT_W] && low_zero;
      end
   end

   // ---- stage 2: shift ----
   norm_beat_t beat_nxt, beat_p2;

   always_comb begin
      beat_nxt      = '0;
      beat_nxt.exp  = exp_p1;
      beat_nxt.sign = sign_p1;
      if (carry_p1) begin
         beat_nxt.mant  = sum_p1[MANT_W:1];
         beat_nxt.shift = SHIFT_W'(CARRY_CODE);
`ifdef FP_NORM_STICKY_EN
         beat_nxt.sticky = sum_p1[0];
`endif
      end else if (zero_p1) begin
         beat_nxt.zero = 1'b1;
      end else begin
         beat_nxt.mant  = sum_p1[MANT_W-1:0] << lzc_p1;
         beat_nxt.shift = lzc_p1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2  <= 1'b0;
         beat_p2 <= '0;
      end else if (adv2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            beat_p2 <= beat_nxt;
         end
      end
   end

   assign out_valid = vld_p2;
   assign out_mant  = beat_p2.mant;
   assign out_shift = beat_p2.shift;
   assign out_exp   = beat_p2.exp;
   assign out_sign  = beat_p2.sign;
   assign out_zero  = beat_p2.zero;
`ifdef FP_NORM_STICKY_EN
   assign out_sticky = beat_p2.sticky;
`else
   // Field is never written non-zero in this build.
   assign out_sticky = beat_p2.sticky & 1'b0;
`endif

endmodule

// File: tb/tb_fp_add_normalizer.sv
// -----------------------------------------------------------------------------
// tb_fp_add_normalizer
// Directed and randomized bench for fp_add_normalizer with an arithmetic
// reference model and an in-order expectation queue.
// -----------------------------------------------------------------------------
module tb_fp_add_normalizer;

`ifdef FP_NORM_STICKY_EN
   localparam logic STICKY_ON = 1'b1;
`else
   localparam logic STICKY_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [24:0] in_sum;
   logic [7:0]  in_exp;
   logic        in_sign;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_mant;
   logic [4:0]  out_shift;
   logic [7:0]  out_exp;
   logic        out_sign;
   logic        out_zero;
   logic        out_sticky;

   always #5 clk = ~clk;

   fp_add_normalizer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sum     (in_sum),
      .in_exp     (in_exp),
      .in_sign    (in_sign),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_mant   (out_mant),
      .out_shift  (out_shift),
      .out_exp    (out_exp),
      .out_sign   (out_sign),
      .out_zero   (out_zero),
      .out_sticky (out_sticky)
   );

   typedef struct {
      logic [23:0] mant;
      logic [4:0]  shift;
      logic [7:0]  exp;
      logic        sign;
      logic        zero;
      logic        sticky;
   } beat_t;

   int          total = 0;
   int          bad   = 0;
   beat_t       q[$];
   bit          holding;
   logic [39:0] held;
   int          nout;
   logic        seen_in_ready;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // Normalize by repeated doubling until the hidden bit sits at 2^23.
   function automatic beat_t model(input logic [24:0] s, input logic [7:0] e, input logic sg);
      beat_t       b;
      int unsigned v;
      int          n;
      b.exp = e; b.sign = sg; b.zero = 1'b0; b.sticky = 1'b0;
      b.mant = '0; b.shift = '0;
      v = 32'(s);
      if (v >= 32'h100_0000) begin
         b.mant  = 24'(v / 2);
         b.shift = 5'd28;
         b.sticky = STICKY_ON && ((v % 2) == 1);
      end else if (v == 0) begin
         b.zero = 1'b1;
      end else begin
         n = 0;
         while (v < 32'h80_0000) begin
            v = v * 2;
            n++;
         end
         b.mant  = 24'(v);
         b.shift = 5'(n);
      end
      return b;
   endfunction

   // One clock: caller has set in_* at the falling edge; check outputs,
   // account for transfers, then advance to the next falling edge.
   task automatic cycle(input logic ordy, output bit took);
      beat_t       e;
      logic [39:0] cur;
      out_ready = ordy;
      took = 1'b0;
      #1;
      seen_in_ready = in_ready;
      cur = {out_mant, out_shift, out_exp, out_sign, out_zero, out_sticky};
      if (!rst) begin
         if (holding) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(cur), 64'(held));
         end
         holding = out_valid && !out_ready;
         held    = cur;
         if (out_valid && out_ready) begin
            nout++;
            if (q.size() == 0) begin
               chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
               e = q.pop_front();
               chk("mant",   64'(out_mant),   64'(e.mant));
               chk("shift",  64'(out_shift),  64'(e.shift));
               chk("exp",    64'(out_exp),    64'(e.exp));
               chk("sign",   64'(out_sign),   64'(e.sign));
               chk("zero",   64'(out_zero),   64'(e.zero));
               chk("sticky", 64'(out_sticky), 64'(e.sticky));
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(in_sum, in_exp, in_sign));
            took = 1'b1;
         end
      end else begin
         holding = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic directed(input string tag, input logic [24:0] s, input logic [7:0] e,
                           input logic sg, input logic [23:0] wm, input logic [4:0] ws,
                           input logic wz, input logic wst);
      bit t;
      in_valid = 1'b1; in_sum = s; in_exp = e; in_sign = sg;
      cycle(1'b1, t);
      chk({tag, "_accept"}, 64'(t), 64'd1);
      in_valid = 1'b0;
      cycle(1'b1, t);
      #1;
      chk({tag, "_latency2"}, 64'(out_valid),  64'd1);
      chk({tag, "_mant"},     64'(out_mant),   64'(wm));
      chk({tag, "_shift"},    64'(out_shift),  64'(ws));
      chk({tag, "_exp"},      64'(out_exp),    64'(e));
      chk({tag, "_sign"},     64'(out_sign),   64'(sg));
      chk({tag, "_zero"},     64'(out_zero),   64'(wz));
      chk({tag, "_sticky"},   64'(out_sticky), 64'(wst));
      cycle(1'b1, t);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   logic [24:0] bp_sum [4];
   bit          t;
   bit          pend;
   int          idx;
   bit          saw_low;
   int          r;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_exp = '0; in_sign = 1'b0;
      out_ready = 1'b0; holding = 1'b0; held = '0; nout = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid",  64'(out_valid),  64'd0);
      chk("rst_in_ready",   64'(in_ready),   64'd1);
      chk("rst_out_mant",   64'(out_mant),   64'd0);
      chk("rst_out_shift",  64'(out_shift),  64'd0);
      chk("rst_out_exp",    64'(out_exp),    64'd0);
      chk("rst_out_sign",   64'(out_sign),   64'd0);
      chk("rst_out_zero",   64'(out_zero),   64'd0);
      chk("rst_out_sticky", 64'(out_sticky), 64'd0);

      // directed cases
      directed("carry",  25'h1800000, 8'h80, 1'b0, 24'hC00000, 5'd28, 1'b0, 1'b0);
      directed("lz15",   25'h0000100, 8'h21, 1'b1, 24'h800000, 5'd15, 1'b0, 1'b0);
      directed("lz0",    25'h0800000, 8'h7F, 1'b0, 24'h800000, 5'd0,  1'b0, 1'b0);
      directed("lz23",   25'h0000001, 8'h03, 1'b0, 24'h800000, 5'd23, 1'b0, 1'b0);
      directed("zero",   25'h0000000, 8'h5A, 1'b1, 24'h000000, 5'd0,  1'b1, 1'b0);
      directed("sticky", 25'h1000001, 8'hFE, 1'b0, 24'h800000, 5'd28, 1'b0, STICKY_ON);

      // backpressure: 4 beats, out_ready low on cycles 3..6
      bp_sum[0] = 25'h1FFFFFF; bp_sum[1] = 25'h0000001;
      bp_sum[2] = 25'h0ABCDEF; bp_sum[3] = 25'h0000000;
      idx = 0; nout = 0; saw_low = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         in_valid = (idx < 4);
         if (idx < 4) begin
            in_sum = bp_sum[idx]; in_exp = 8'(8'h10 + idx); in_sign = idx[0];
         end
         cycle(!(k >= 3 && k <= 6), t);
         if (!seen_in_ready) saw_low = 1'b1;
         if (t) idx++;
      end
      in_valid = 1'b0;
      chk("bp_in_ready_dropped", 64'(saw_low), 64'd1);
      chk("bp_beats_accepted",   64'(idx),     64'd4);
      chk("bp_beats_out",        64'(nout),    64'd4);
      chk("bp_queue_empty",      64'(q.size()), 64'd0);

      // reset with two beats in flight
      in_valid = 1'b1; in_sum = 25'h0001234; in_exp = 8'h44; in_sign = 1'b0;
      cycle(1'b1, t);
      in_sum = 25'h1234567; in_exp = 8'h55; in_sign = 1'b1;
      cycle(1'b1, t);
      in_valid = 1'b0;
      rst = 1'b1;
      cycle(1'b0, t);
      rst = 1'b0;
      q.delete();
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready",  64'(in_ready),  64'd1);
      chk("midrst_out_mant",  64'(out_mant),  64'd0);
      nout = 0;
      repeat (6) cycle(1'b1, t);
      chk("midrst_no_emit", 64'(nout), 64'd0);

      // randomized traffic with random backpressure
      pend = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!pend) begin
            in_valid = ($urandom_range(0, 9) < 7);
            r = int'($urandom_range(0, 3));
            case (r)
               0: in_sum = 25'($urandom);
               1: in_sum = 25'h1000000 | 25'($urandom);
               2: in_sum = 25'(24'($urandom) >> $urandom_range(0, 23));
               default: in_sum = ($urandom_range(0, 3) == 0) ? 25'd0
                                 : 25'(25'd1 << $urandom_range(0, 24));
            endcase
            in_exp  = 8'($urandom);
            in_sign = 1'($urandom);
         end
         cycle(1'($urandom_range(0, 9) < 7), t);
         pend = in_valid && !t;
      end
      in_valid = 1'b0;
      for (int i = 0; i < 10 && q.size() != 0; i++) cycle(1'b1, t);
      chk("rand_drain_empty", 64'(q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
